// File: rtl/current_mirror_cal.sv
// current_mirror_cal
//   Calibration sequencer for the 2-bit current-mirror gain select. It steps
//   the mirror code linearly from 0 (highest gain) to 3 (lowest gain). For
//   each code it waits SETTLE_CYC cycles, then majority-votes NSAMP comparator
//   samples. The first code whose vote does not report "above target" is
//   latched as the calibrated code.
//
// Ports
//   clk       system clock
//   rstn      synchronous active-low reset
//   start     single-cycle calibration request (accepted in IDLE/DONE only)
//   cmp_hi    comparator, 1 = mirrored current above target (synchronised)
//   ovr_en    manual override enable; aborts a running calibration
//   ovr_code  manual mirror code, applied while ovr_en=1
//   cfg_mirr  registered mirror code to the current_mirror array
//   cal_code  last calibrated code
//   busy      calibration in progress
//   done      calibration completed (level, held until next start/reset)
//   sat_err   comparator still high at code 3
//
// Optional build macro
//   CAL_RECAL_EN  when defined, a calibration restarts automatically after
//                 RECAL_PERIOD idle cycles in DONE (counter held clear while
//                 ovr_en=1 or outside DONE).
module current_mirror_cal #(
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned NSAMP        = 5,
  parameter logic [1:0]  RESET_CODE   = 2'b01,
  parameter int unsigned RECAL_PERIOD = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       cmp_hi,
  input  logic       ovr_en,
  input  logic [1:0] ovr_code,
  output logic [1:0] cfg_mirr,
  output logic [1:0] cal_code,
  output logic       busy,
  output logic       done,
  output logic       sat_err
);

  localparam int unsigned CMAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned OW   = $clog2(NSAMP + 1);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be >= 1");
  end
  if ((NSAMP < 1) || ((NSAMP % 2) == 0)) begin : g_bad_nsamp
    $error("NSAMP must be odd and >= 1");
  end
  if (RECAL_PERIOD < 1) begin : g_bad_recal
    $error("RECAL_PERIOD must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [1:0]    cal_q, cal_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          too_high;
  logic          start_acc;
  logic          recal_trig;

`ifdef CAL_RECAL_EN
  localparam int unsigned RW = $clog2(RECAL_PERIOD + 1);
  logic [RW-1:0] recal_q, recal_d;

  // Counts idle cycles in DONE; any other state or an override clears it.
  always_comb begin
    recal_d    = '0;
    recal_trig = 1'b0;
    if ((state_q == S_DONE) && !ovr_en) begin
      if (recal_q == RW'(RECAL_PERIOD - 1)) begin
        recal_trig = 1'b1;
      end else begin
        recal_d = recal_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      recal_q <= '0;
    end else begin
      recal_q <= recal_d;
    end
  end
`else
  assign recal_trig = 1'b0;
`endif

  assign too_high  = ones_q > OW'(NSAMP / 2);
  assign start_acc = (start || recal_trig) && !ovr_en &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cfg_d   = cfg_q;
    cal_d   = cal_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sat_d   = sat_q;
    cyc_d   = cyc_q;
    ones_d  = ones_q;

    if (ovr_en) begin
      // Override wins in every state; a running search is abandoned.
      cfg_d = ovr_code;
      if (busy_q) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cyc_d   = '0;
        ones_d  = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          cfg_d = cal_q;
          if (start_acc) begin
            state_d = S_SETTLE;
            code_d  = '0;
            cfg_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            sat_d   = 1'b0;
            cyc_d   = '0;
            ones_d  = '0;
          end
        end
        S_SETTLE: begin
          cfg_d = code_q;
          if (cyc_q == CW'(SETTLE_CYC - 1)) begin
            cyc_d   = '0;
            state_d = S_SAMPLE;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          cfg_d  = code_q;
          ones_d = ones_q + OW'(cmp_hi);
          if (cyc_q == CW'(NSAMP - 1)) begin
            cyc_d   = '0;
            state_d = S_DECIDE;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_DECIDE: begin
          if (too_high && (code_q != 2'd3)) begin
            code_d  = code_q + 2'd1;
            cfg_d   = code_q + 2'd1;
            ones_d  = '0;
            state_d = S_SETTLE;
          end else begin
            // Either the first non-overshooting code or saturation at 3.
            cal_d   = code_q;
            cfg_d   = code_q;
            sat_d   = too_high;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      cfg_q   <= RESET_CODE;
      cal_q   <= RESET_CODE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      cyc_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cfg_q   <= cfg_d;
      cal_q   <= cal_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      cyc_q   <= cyc_d;
      ones_q  <= ones_d;
    end
  end

  assign cfg_mirr = cfg_q;
  assign cal_code = cal_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sat_err  = sat_q;

endmodule

// File: tb/tb_current_mirror_cal.sv
// tb_current_mirror_cal
//   Directed bench for current_mirror_cal at default SETTLE_CYC/NSAMP
//   (22 cycles per code) with RECAL_PERIOD=100. Cycle numbers are counted
//   in rising edges after the edge on which start was driven.
module tb_current_mirror_cal;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       cmp_hi;
  logic       ovr_en;
  logic [1:0] ovr_code;
  logic [1:0] cfg_mirr;
  logic [1:0] cal_code;
  logic       busy;
  logic       done;
  logic       sat_err;

  int total = 0;
  int bad   = 0;

  current_mirror_cal #(
    .SETTLE_CYC  (16),
    .NSAMP       (5),
    .RESET_CODE  (2'b01),
    .RECAL_PERIOD(100)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .cmp_hi  (cmp_hi),
    .ovr_en  (ovr_en),
    .ovr_code(ovr_code),
    .cfg_mirr(cfg_mirr),
    .cal_code(cal_code),
    .busy    (busy),
    .done    (done),
    .sat_err (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // One record per calibration run: comparator pattern per code
  // ({code3,code2,code1,code0}, bit j = j-th sample), expected result.
  typedef struct {
    logic [19:0] pat;
    logic [1:0]  exp_code;
    logic        exp_sat;
    int          exp_done;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_at;
    int bad_seq;
    int e;
    int c;
    int j;
    done_at = 0;
    bad_seq = 0;
    cmp_hi  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b1 || done !== 1'b0 || sat_err !== 1'b0 || cfg_mirr !== 2'd0)
      bad_seq++;
    for (int n = 2; n <= 130 && done_at == 0; n++) begin
      e = n - 1;
      c = (e - 1) / 22;
      j = (e - 1) % 22 + 1;
      // Outside the sample window the comparator reads 1; it must be ignored.
      cmp_hi = 1'b1;
      if (j >= 17 && j <= 21 && c < 4) cmp_hi = v.pat[5*c + j - 17];
      tick();
      if (done === 1'b1) done_at = n;
      else if (busy !== 1'b1 || sat_err !== 1'b0 || cfg_mirr !== 2'(e / 22)) bad_seq++;
    end
    check($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
    check($sformatf("v%0d_cal_code", idx), int'(cal_code), int'(v.exp_code));
    check($sformatf("v%0d_sat_err", idx), int'(sat_err), int'(v.exp_sat));
    check($sformatf("v%0d_busy_low", idx), int'(busy), 0);
    check($sformatf("v%0d_cfg_final", idx), int'(cfg_mirr), int'(v.exp_code));
    check($sformatf("v%0d_step_errors", idx), bad_seq, 0);
  endtask

  initial begin
    int done_at;
    int busy_at;
    int flag;

    vecs[0] = '{pat: {5'b00000, 5'b00000, 5'b11111, 5'b11111}, exp_code: 2'd2, exp_sat: 1'b0, exp_done: 67};
    vecs[1] = '{pat: {5'b10101, 5'b10101, 5'b10101, 5'b10101}, exp_code: 2'd3, exp_sat: 1'b1, exp_done: 89};
    vecs[2] = '{pat: {5'b11111, 5'b11111, 5'b11111, 5'b01010}, exp_code: 2'd0, exp_sat: 1'b0, exp_done: 23};
    vecs[3] = '{pat: {5'b11111, 5'b11111, 5'b00011, 5'b11100}, exp_code: 2'd1, exp_sat: 1'b0, exp_done: 45};

    rstn     = 1'b0;
    start    = 1'b0;
    cmp_hi   = 1'b0;
    ovr_en   = 1'b0;
    ovr_code = 2'd0;
    tick();
    tick();
    check("rst_cfg_mirr", int'(cfg_mirr), 1);
    check("rst_cal_code", int'(cal_code), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sat_err", int'(sat_err), 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], i);
      repeat (3) tick();
    end

    // Override abort mid-run (cal_code is 1 from the last vector).
    cmp_hi = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (28) tick();
    check("ovr_pre_busy", int'(busy), 1);
    ovr_en   = 1'b1;
    ovr_code = 2'd3;
    tick();
    check("ovr_cfg", int'(cfg_mirr), 3);
    check("ovr_busy", int'(busy), 0);
    check("ovr_done", int'(done), 0);
    check("ovr_cal_kept", int'(cal_code), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("ovr_start_ignored_busy", int'(busy), 0);
    check("ovr_start_ignored_cfg", int'(cfg_mirr), 3);
    ovr_code = 2'd2;
    tick();
    check("ovr_code_follow", int'(cfg_mirr), 2);
    ovr_en = 1'b0;
    tick();
    check("ovr_release_cfg", int'(cfg_mirr), 1);

    // Start re-asserted at cycle 10 of a run must not restart it.
    cmp_hi  = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    done_at = 0;
    for (int n = 2; n <= 60 && done_at == 0; n++) begin
      start = (n == 10);
      tick();
      if (done === 1'b1) done_at = n;
    end
    start = 1'b0;
    check("busy_start_done_cycle", done_at, 23);
    check("busy_start_cal", int'(cal_code), 0);

    // Reset at cycle 40 of a run that would otherwise saturate.
    cmp_hi = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (38) tick();
    check("midrst_pre_busy", int'(busy), 1);
    rstn = 1'b0;
    tick();
    check("midrst_cfg_mirr", int'(cfg_mirr), 1);
    check("midrst_cal_code", int'(cal_code), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_sat_err", int'(sat_err), 0);
    rstn = 1'b1;
    tick();

    // Reach DONE with cal_code=0, then watch idle behaviour.
    cmp_hi  = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    done_at = 0;
    for (int n = 2; n <= 60 && done_at == 0; n++) begin
      tick();
      if (done === 1'b1) done_at = n;
    end
    check("idle_run_done_cycle", done_at, 23);
    cmp_hi = 1'b1;
`ifdef CAL_RECAL_EN
    busy_at = 0;
    for (int m = 1; m <= 200 && busy_at == 0; m++) begin
      tick();
      if (busy === 1'b1) busy_at = m;
    end
    check("recal_busy_delay", busy_at, 100);
    repeat (10) tick();
    check("recal_cal_held", int'(cal_code), 0);
    check("recal_cfg_stepping", int'(cfg_mirr), 0);
    done_at = 0;
    for (int n = 1; n <= 200 && done_at == 0; n++) begin
      tick();
      if (done === 1'b1) done_at = n;
    end
    check("recal_done_seen", int'(done_at != 0), 1);
    check("recal_new_cal", int'(cal_code), 3);
    check("recal_new_sat", int'(sat_err), 1);
`else
    flag    = 0;
    busy_at = 0;
    for (int m = 1; m <= 1000; m++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b1) flag++;
    end
    check("no_recal_idle_errors", flag, busy_at);
    check("no_recal_cal", int'(cal_code), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/current_mirror_cal.md
Name: current_mirror_cal

Overview:
Digital calibration sequencer for the 2-bit current-mirror gain select (cfg_mirr). It steps the mirror code, waits for the analog output to settle, and majority-votes an external comparator that flags output current above target. It then latches the first code that does not overshoot. It sits between the bias/cal control register block and the current_mirror array, and drives cfg_mirr directly.

Parameters:
SETTLE_CYC, 16, clock cycles to wait after each code change before sampling (>=1)
NSAMP, 5, comparator samples per code, odd, >=1
RESET_CODE, 2'b01, cfg_mirr / cal_code value after reset (nominal mirror gain)
RECAL_PERIOD, 4096, idle cycles in DONE before automatic re-calibration (CAL_RECAL_EN only)

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
start  input  1  single-cycle calibration request
cmp_hi  input  1  comparator: 1 = mirrored current above target (already synchronised)
ovr_en  input  1  manual override enable
ovr_code  input  2  manual mirror code
cfg_mirr  output  2  registered code to current_mirror cfg_mirr[1:0]
cal_code  output  2  last calibrated code
busy  output  1  calibration in progress
done  output  1  calibration completed (level)
sat_err  output  1  comparator still high at code 3

Behaviour:
- One clock (clk); reset synchronous, active-low (rstn sampled on rising clk).
- Reset values: cfg_mirr=RESET_CODE, cal_code=RESET_CODE, busy=0, done=0, sat_err=0, FSM=IDLE, counters=0.
- Code semantics: gain decreases monotonically with code (0 highest, 3 lowest). Search is linear 0->3.
- FSM states: IDLE, SETTLE, SAMPLE, DECIDE, DONE.
- IDLE/DONE: start=1 && ovr_en=0 -> SETTLE. Next cycle: code=0, cfg_mirr=0, busy=1, done=0, sat_err=0, ones-counter cleared.
- SETTLE: remain exactly SETTLE_CYC cycles, then SAMPLE.
- SAMPLE: exactly NSAMP cycles. cmp_hi is accumulated each cycle into the ones-counter, width $clog2(NSAMP+1). Then DECIDE.
- DECIDE (1 cycle): too_high = ones > NSAMP/2 (integer division).
  - too_high && code<3 -> code+1, cfg_mirr updated next cycle, counter cleared, SETTLE.
  - !too_high -> cal_code=code, DONE.
  - too_high && code==3 -> cal_code=3, sat_err=1, DONE.
- Per-code cost: SETTLE_CYC+NSAMP+1 cycles (22 at defaults).
- done rises (SETTLE_CYC+NSAMP+1)*(k+1)+1 cycles after the start edge, k = final code. busy falls on the same cycle.
- done and sat_err hold until the next accepted start or reset.
- start while busy: ignored (no restart, no queue).
- start while ovr_en=1: ignored.
- ovr_en=1: cfg_mirr=ovr_code from next cycle, any state.
  - If the FSM is busy, calibration aborts to IDLE: busy=0, done=0, cal_code unchanged.
- ovr_en 1->0: cfg_mirr returns to cal_code next cycle.
- In IDLE/DONE without override: cfg_mirr=cal_code.
- rstn low mid-calibration: all outputs take reset values on that edge.
- cmp_hi is ignored outside SAMPLE.

Optional Feature:
- Macro: CAL_RECAL_EN.
- Defined: a free counter runs only in DONE with ovr_en=0. When it reaches RECAL_PERIOD, a calibration starts as if start=1, and the counter clears.
  - The counter clears on any leave of DONE and on ovr_en=1.
  - During re-cal, cfg_mirr steps from 0 as normal. cal_code keeps its old value until the new DECIDE result.
- Undefined: no counter logic. DONE persists until start, ovr_en or reset.

Test Plan:
- Reset: rstn=0 for 2 cycles -> cfg_mirr=01, cal_code=01, busy=0, done=0, sat_err=0.
- Normal: start pulse; cmp_hi=1 while cfg_mirr in {0,1}, cmp_hi=0 at code 2 -> cfg_mirr sequence 0,1,2; cal_code=2; done rises 67 cycles after start; sat_err=0.
- Majority/saturation: cmp_hi=1 in 3 of 5 samples at every code -> codes 0..3 visited; cal_code=3; sat_err=1; done at cycle 89.
  - Second run with 2 of 5 ones at code 0 -> cal_code=0, done at 23.
- Override abort: start, then ovr_en=1 with ovr_code=3 at cycle 30 -> cfg_mirr=3 at 31, busy=0, done=0, cal_code unchanged. A start while ovr_en=1 is ignored.
- Busy start and reset: start re-asserted at cycle 10 of a run -> run unaffected. rstn=0 at cycle 40 -> reset values next edge.
- CAL_RECAL_EN defined, RECAL_PERIOD=100: after done, hold idle -> busy rises 100 cycles later, cal_code retained until the new result. Undefined -> no auto restart in 1000 cycles.
